// File: rtl/reg_op_sequencer.sv
// ---------------------------------------------------------------------------
// reg_op_sequencer
//
// Purpose:
//   Command-driven controller for the 4-bit PicoComputer `register` unit.
//   Accepts one operation per valid/ready handshake and expands it into a
//   train of single-cycle control pulses (cl/ld/inc/dec/sr/sl) with the
//   matching serial-in bit (ir/il) or parallel load data (in). The
//   register's output is read back so rotates can feed the outgoing bit
//   back in.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   cmd_valid_i   command offered
//   cmd_ready_o   command can be accepted (IDLE only)
//   cmd_op_i[2:0] opcode: CLR, LD, INC, DEC, SHR, SHL, ROR, ROL
//   cmd_data_i    LD value; bit 0 is the SHR/SHL fill bit
//   cmd_cnt_i     step count for INC..ROL
//   reg_q_i       register output read-back
//   cl_o..sl_o    register controls, at most one high per cycle
//   ir_o / il_o   serial bit into register bit 3 (sr) / bit 0 (sl)
//   in_o          parallel load data, nonzero only during an LD pulse
//   busy_o        high in RUN and DONE
//   done_o        one-cycle completion pulse
// ---------------------------------------------------------------------------
module reg_op_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [2:0] cmd_op_i,
    input  logic [3:0] cmd_data_i,
    input  logic [3:0] cmd_cnt_i,
    input  logic [3:0] reg_q_i,
    output logic       cl_o,
    output logic       ld_o,
    output logic       inc_o,
    output logic       dec_o,
    output logic       sr_o,
    output logic       sl_o,
    output logic       ir_o,
    output logic       il_o,
    output logic [3:0] in_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam logic [2:0] OP_CLR = 3'b000;
    localparam logic [2:0] OP_LD  = 3'b001;
    localparam logic [2:0] OP_INC = 3'b010;
    localparam logic [2:0] OP_DEC = 3'b011;
    localparam logic [2:0] OP_SHR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_ROR = 3'b110;
    localparam logic [2:0] OP_ROL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [3:0] data_q, data_d;
    logic [3:0] rem_q, rem_d;
    logic [3:0] load_cnt;
    logic       run;

    // Only bits 0 and 3 of the register are needed (rotate feedback).
    logic unused_reg_bits;
    assign unused_reg_bits = ^reg_q_i[2:1];

    // CLR and LD are always a single pulse regardless of the count field.
    assign load_cnt = (cmd_op_i == OP_CLR || cmd_op_i == OP_LD) ? 4'd1 : cmd_cnt_i;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    op_d    = cmd_op_i;
                    data_d  = cmd_data_i;
                    rem_d   = load_cnt;
                    // A zero count skips RUN and completes on the next cycle.
                    state_d = (load_cnt != 4'd0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                rem_d = rem_q - 4'd1;
                if (rem_q == 4'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= 3'd0;
            data_q  <= 4'd0;
            rem_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
        end
    end

    // Controls decode from the registered state and op; because the state
    // register is cleared asynchronously, reset silences them immediately.
    assign run         = (state_q == ST_RUN);
    assign cmd_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign done_o      = (state_q == ST_DONE);

    assign cl_o  = run && (op_q == OP_CLR);
    assign ld_o  = run && (op_q == OP_LD);
    assign inc_o = run && (op_q == OP_INC);
    assign dec_o = run && (op_q == OP_DEC);
    assign sr_o  = run && (op_q == OP_SHR || op_q == OP_ROR);
    assign sl_o  = run && (op_q == OP_SHL || op_q == OP_ROL);

    // Rotates sample the live register output each step, so a multi-step
    // rotate always feeds back the bit that is currently shifting out.
    assign ir_o = sr_o && ((op_q == OP_ROR) ? reg_q_i[0] : data_q[0]);
    assign il_o = sl_o && ((op_q == OP_ROL) ? reg_q_i[3] : data_q[0]);
    assign in_o = ld_o ? data_q : 4'h0;

endmodule

// File: tb/tb_reg_op_sequencer.sv
module tb_reg_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [3:0] cmd_data = 4'd0;
    logic [3:0] cmd_cnt = 4'd0;
    logic [3:0] reg_q;
    logic       cl, ld, inc, dec, sr, sl, ir, il;
    logic [3:0] in_w;
    logic       busy, done;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    // Behavioural 4-bit register driven by the sequencer (not reset by rst_n).
    logic [3:0] r = 4'h0;
    // Reference value of the register, from the command-level model.
    logic [3:0] m = 4'h0;

    always #5 clk = ~clk;

    assign reg_q = r;

    reg_op_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_op_i   (cmd_op),
        .cmd_data_i (cmd_data),
        .cmd_cnt_i  (cmd_cnt),
        .reg_q_i    (reg_q),
        .cl_o       (cl),
        .ld_o       (ld),
        .inc_o      (inc),
        .dec_o      (dec),
        .sr_o       (sr),
        .sl_o       (sl),
        .ir_o       (ir),
        .il_o       (il),
        .in_o       (in_w),
        .busy_o     (busy),
        .done_o     (done)
    );

    always @(posedge clk) begin
        if (cl)       r <= 4'h0;
        else if (ld)  r <= in_w;
        else if (inc) r <= r + 4'd1;
        else if (dec) r <= r - 4'd1;
        else if (sr)  r <= {ir, r[3:1]};
        else if (sl)  r <= {r[2:0], il};
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ctl_count();
        return int'(cl) + int'(ld) + int'(inc) + int'(dec) + int'(sr) + int'(sl);
    endfunction

    // Command-level reference: final register value from plain arithmetic.
    function automatic logic [3:0] ref_next(input logic [3:0] v, input logic [2:0] op,
                                            input logic [3:0] d, input int n);
        int x;
        int k;
        int fill;
        x = int'(v);
        fill = int'(d[0]);
        k = n % 4;
        case (op)
            3'd0: return 4'h0;
            3'd1: return d;
            3'd2: return 4'((x + n) % 16);
            3'd3: return 4'((x - n + 16) % 16);
            3'd4: begin
                if (n >= 4) return (fill != 0) ? 4'hF : 4'h0;
                return 4'((x >> n) | ((fill != 0) ? ((15 << (4 - n)) & 15) : 0));
            end
            3'd5: begin
                if (n >= 4) return (fill != 0) ? 4'hF : 4'h0;
                return 4'(((x << n) & 15) | ((fill != 0) ? ((1 << n) - 1) : 0));
            end
            3'd6: return 4'(((x >> k) | (x << (4 - k))) & 15);
            default: return 4'(((x << k) | (x >> (4 - k))) & 15);
        endcase
    endfunction

    // Structural rules that hold every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("onehot_ctl", int'(ctl_count() <= 1), 1);
            chk("idle_serial", int'((!sr && ir) || (!sl && il) || (!ld && in_w != 4'h0)), 0);
        end
    end

    // Issue one command, track its pulses and completion, check the result.
    task automatic issue(input logic [2:0] op, input logic [3:0] d, input logic [3:0] n,
                         input logic [3:0] exp_reg, input string tag);
        int guard;
        int exp_n;
        int spec;
        int any;
        int c;
        bit seen;
        exp_n = (op <= 3'd1) ? 1 : int'(n);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_data = d;
        cmd_cnt = n;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, " accept"}, int'(cmd_ready), 1);
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        spec = 0;
        any = 0;
        seen = 1'b0;
        c = 1;
        while (c <= 40) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            any += ctl_count();
            case (op)
                3'd0: spec += int'(cl);
                3'd1: if (ld) begin
                    spec++;
                    chk({tag, " in"}, int'(in_w), int'(d));
                end
                3'd2: spec += int'(inc);
                3'd3: spec += int'(dec);
                3'd4: if (sr) begin
                    spec++;
                    chk({tag, " ir_fill"}, int'(ir), int'(d[0]));
                end
                3'd5: if (sl) begin
                    spec++;
                    chk({tag, " il_fill"}, int'(il), int'(d[0]));
                end
                3'd6: if (sr) begin
                    spec++;
                    chk({tag, " ir_rot"}, int'(ir), int'(r[0]));
                end
                default: if (sl) begin
                    spec++;
                    chk({tag, " il_rot"}, int'(il), int'(r[3]));
                end
            endcase
            @(negedge clk);
            c++;
        end
        chk({tag, " done_seen"}, int'(seen), 1);
        chk({tag, " done_cycle"}, c, exp_n + 1);
        chk({tag, " pulses"}, spec, exp_n);
        chk({tag, " all_ctl"}, any, exp_n);
        @(negedge clk);
        chk({tag, " ready_after"}, int'(cmd_ready), 1);
        chk({tag, " done_once"}, int'(done), 0);
        chk({tag, " reg"}, int'(r), int'(exp_reg));
        $display("cmd %s op=%0d data=%h cnt=%0d reg=%h exp=%h pulses=%0d", tag, op, d, n, r,
                 exp_reg, spec);
    endtask

    typedef struct {
        logic [2:0] op;
        logic [3:0] d;
        logic [3:0] n;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[17];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int cnt5;
        int dn;
        int ctl;
        logic [2:0] op;
        logic [3:0] d;
        logic [3:0] n;
        logic [3:0] e;

        tbl[0]  = '{3'd1, 4'hA, 4'd0,  4'hA};
        tbl[1]  = '{3'd2, 4'h0, 4'd3,  4'hD};
        tbl[2]  = '{3'd1, 4'h9, 4'd0,  4'h9};
        tbl[3]  = '{3'd6, 4'h0, 4'd1,  4'hC};
        tbl[4]  = '{3'd7, 4'h0, 4'd4,  4'hC};
        tbl[5]  = '{3'd1, 4'hF, 4'd0,  4'hF};
        tbl[6]  = '{3'd2, 4'h0, 4'd2,  4'h1};
        tbl[7]  = '{3'd3, 4'h0, 4'd0,  4'h1};
        tbl[8]  = '{3'd1, 4'h4, 4'd0,  4'h4};
        tbl[9]  = '{3'd5, 4'h1, 4'd2,  4'h3};
        tbl[10] = '{3'd0, 4'h0, 4'd7,  4'h0};
        tbl[11] = '{3'd4, 4'h1, 4'd3,  4'hE};
        tbl[12] = '{3'd3, 4'h0, 4'd5,  4'h9};
        tbl[13] = '{3'd6, 4'h0, 4'd6,  4'h6};
        tbl[14] = '{3'd1, 4'h5, 4'd9,  4'h5};
        tbl[15] = '{3'd7, 4'h0, 4'd3,  4'hA};
        tbl[16] = '{3'd5, 4'h0, 4'd15, 4'h0};

        // Reset values, observed while reset is held.
        #2 rst_n = 1'b0;
        #1;
        chk("rst ready", int'(cmd_ready), 1);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst ctl", ctl_count(), 0);
        chk("rst in", int'(in_w), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst ready", int'(cmd_ready), 1);
        chk("post_rst busy", int'(busy), 0);
        mon_en = 1'b1;

        // Table-driven commands with hand-derived results.
        for (int i = 0; i < 17; i++) begin
            issue(tbl[i].op, tbl[i].d, tbl[i].n, tbl[i].exp, $sformatf("tbl%0d", i));
            m = tbl[i].exp;
        end

        // cmd_valid held high: second command waits for ready, and fields
        // changed while busy must not disturb the running SHL.
        issue(3'd1, 4'h4, 4'd0, 4'h4, "b2b_pre");
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = 3'd5;
        cmd_data = 4'h1;
        cmd_cnt = 4'd2;
        chk("b2b ready0", int'(cmd_ready), 1);
        @(posedge clk);
        @(negedge clk);
        cmd_op = 3'd0;
        cmd_data = 4'h0;
        cmd_cnt = 4'd9;
        c = 1;
        while (!cmd_ready && c < 20) begin
            if (c == 3) begin
                chk("b2b done1", int'(done), 1);
                chk("b2b reg1", int'(r), 4'h3);
            end
            @(negedge clk);
            c++;
        end
        chk("b2b reaccept_gap", c, 4);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("b2b cl", int'(cl), 1);
        @(negedge clk);
        chk("b2b done2", int'(done), 1);
        @(negedge clk);
        chk("b2b reg2", int'(r), 0);
        chk("b2b ready2", int'(cmd_ready), 1);
        $display("cmd b2b SHL then CLR gap=%0d reg=%h", c, r);
        m = 4'h0;

        // Reset at the 5th pulse of SHR cnt=15.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = 3'd4;
        cmd_data = 4'h1;
        cmd_cnt = 4'd15;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cnt5 = 0;
        c = 0;
        while (c < 30) begin
            if (sr) cnt5++;
            if (cnt5 == 5) break;
            @(negedge clk);
            c++;
        end
        chk("rstmid reached5", cnt5, 5);
        rst_n = 1'b0;
        #1;
        chk("rstmid sr", int'(sr), 0);
        chk("rstmid busy", int'(busy), 0);
        chk("rstmid done", int'(done), 0);
        chk("rstmid ready", int'(cmd_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        ctl = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            dn += int'(done);
            ctl += ctl_count();
        end
        chk("rstmid no_done", dn, 0);
        chk("rstmid no_ctl", ctl, 0);
        chk("rstmid ready_after", int'(cmd_ready), 1);
        $display("cmd rstmid SHR cnt=15 pulses_before_reset=%0d", cnt5);

        // Randomized commands against the command-level model.
        issue(3'd1, 4'h0, 4'd0, 4'h0, "resync");
        m = 4'h0;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            d = 4'($urandom_range(0, 15));
            n = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) n = 4'd0;
            e = ref_next(m, op, d, int'(n));
            issue(op, d, n, e, $sformatf("rnd%0d", i));
            m = e;
        end

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
